mult_seq: RTL and testbench

- Parametrised multi-cycle shift-add multiplier: next generation of the fixed 8x8 en/ack multiplier.
- Adds operand width `WIDTH`, a per-operation signed/unsigned mode, a busy indication and a zero-operand fast path.
- Sits behind the same en/ack request-acknowledge style of interface, driven by a testbench or controller.

---
 rtl/mult_pkg.sv | 16 +
 rtl/mult_if.sv | 36 +++
 rtl/mult_seq.sv | 169 ++++++++++++++++
 tb/tb_mult_seq.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM state
// encoding and the nominal completion latency used for ack timing.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mult_state_e;

    // Edges from operand capture to the completing edge on the normal path.
    function automatic int mult_latency(input int width);
        return width;
    endfunction

endpackage : mult_pkg

// File: rtl/mult_if.sv
// Request/acknowledge bundle between a controller and the multiplier.
// The controller (master) drives the request and operands. The multiplier
// (slave) returns the product, the one-cycle ack and the busy flag.
interface mult_if #(
    parameter int WIDTH = 8
) ();

    logic                 en;
    logic                 sgn;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [2*WIDTH-1:0]   out;
    logic                 ack;
    logic                 busy;

    modport master (
        output en,
        output sgn,
        output a,
        output b,
        input  out,
        input  ack,
        input  busy
    );

    modport slave (
        input  en,
        input  sgn,
        input  a,
        input  b,
        output out,
        output ack,
        output busy
    );

endinterface : mult_if

// File: rtl/mult_seq.sv
// Multi-cycle shift-add multiplier, signed or unsigned per operation.
// Signed operands are reduced to magnitudes at capture. The unsigned
// magnitude product is built one multiplier bit per CALC edge. The sign is
// re-applied on the completing edge. A zero operand can optionally skip
// straight to DONE.
module mult_seq
    import mult_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit EARLY_ZERO = 1'b1
) (
    input  logic  clk,
    input  logic  reset,
    mult_if.slave bus
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
    localparam logic [PW-1:0]    ONE_P    = PW'(1);
    localparam logic [CW-1:0]    ONE_C    = CW'(1);
    localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);

    mult_state_e      state_r;
    mult_state_e      state_nxt_s;

    logic [PW-1:0]    mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [PW-1:0]    acc_r;
    logic [CW-1:0]    cnt_r;
    logic             neg_r;
    logic [PW-1:0]    out_r;
    logic             ack_r;

    logic [WIDTH-1:0] a_mag_s;
    logic [WIDTH-1:0] b_mag_s;
    logic             zero_op_s;
    logic             fast_s;
    logic             last_s;
    logic [PW-1:0]    addend_s;
    logic [PW-1:0]    acc_sum_s;
    logic [PW-1:0]    result_s;

    // Operand magnitudes, the fast-path decision and the accumulate/sign-fix datapath.
    always_comb begin
        a_mag_s   = bus.a;
        b_mag_s   = bus.b;
        addend_s  = '0;
        if (bus.sgn && bus.a[WIDTH-1]) begin
            a_mag_s = ~bus.a + ONE_W;
        end else begin
            a_mag_s = bus.a;
        end
        if (bus.sgn && bus.b[WIDTH-1]) begin
            b_mag_s = ~bus.b + ONE_W;
        end else begin
            b_mag_s = bus.b;
        end
        zero_op_s = (bus.a == '0) || (bus.b == '0);
        fast_s    = EARLY_ZERO && zero_op_s;
        last_s    = (cnt_r == LAST_CNT);
        if (mplier_r[0]) begin
            addend_s = mcand_r;
        end else begin
            addend_s = '0;
        end
        acc_sum_s = acc_r + addend_s;
        if (neg_r) begin
            result_s = ~acc_sum_s + ONE_P;
        end else begin
            result_s = acc_sum_s;
        end
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode: requests are honoured only in IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.en) begin
                    if (fast_s) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = CALC;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Datapath: capture operands in IDLE, shift-add in CALC, drop ack in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_r  <= '0;
            mplier_r <= '0;
            acc_r    <= '0;
            cnt_r    <= '0;
            neg_r    <= 1'b0;
            out_r    <= '0;
            ack_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    ack_r <= 1'b0;
                    if (bus.en) begin
                        mcand_r  <= {{WIDTH{1'b0}}, a_mag_s};
                        mplier_r <= b_mag_s;
                        neg_r    <= bus.sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        acc_r    <= '0;
                        cnt_r    <= '0;
                        if (fast_s) begin
                            out_r <= '0;
                            ack_r <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    acc_r    <= acc_sum_s;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    cnt_r    <= cnt_r + ONE_C;
                    if (last_s) begin
                        // Product leaves on the same edge as the last partial product.
                        out_r <= result_s;
                        ack_r <= 1'b1;
                    end else begin
                        ack_r <= 1'b0;
                    end
                end
                DONE: begin
                    ack_r <= 1'b0;
                end
                default: begin
                    ack_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out  = out_r;
    assign bus.ack  = ack_r;
    assign bus.busy = (state_r != IDLE);

endmodule : mult_seq

// File: tb/tb_mult_seq.sv
// Scoreboard bench for mult_seq. dut0 has the zero fast path and dut1 runs
// at full latency. The driver pushes reference products and due cycles. The
// per-DUT monitors pop and compare the queued entry on every ack.
module tb_mult_seq;
    import mult_pkg::*;

    localparam int W  = 8;
    localparam int PW = 2 * W;

    typedef struct {
        logic [PW-1:0] prod;
        int            due;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mult_if #(.WIDTH(W)) bus0 ();
    mult_if #(.WIDTH(W)) bus1 ();

    mult_seq #(.WIDTH(W), .EARLY_ZERO(1'b1)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    mult_seq #(.WIDTH(W), .EARLY_ZERO(1'b0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    exp_t          q0[$];
    exp_t          q1[$];
    int            tests = 0;
    int            fails = 0;
    int            cyc   = 0;
    int            acks0 = 0;
    int            acks1 = 0;
    logic [PW-1:0] last_prod[2];

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: the mathematical product of the operands as integers, kept to 2*W bits.
    function automatic logic [PW-1:0] ref_mul(input bit s, input logic [W-1:0] x, input logic [W-1:0] y);
        longint vx;
        longint vy;
        longint p;
        vx = s ? longint'($signed(x)) : longint'(x);
        vy = s ? longint'($signed(y)) : longint'(y);
        p  = vx * vy;
        return p[PW-1:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic busy_of(input int which);
        return (which == 0) ? bus0.busy : bus1.busy;
    endfunction

    function automatic int qsize(input int which);
        return (which == 0) ? q0.size() : q1.size();
    endfunction

    // Monitor for dut0: every ack must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus0.ack === 1'b1) begin
            acks0++;
            if (q0.size() == 0) begin
                check("unexpected_ack0", 32'd1, 32'd0);
            end else begin
                e = q0.pop_front();
                check("prod0", 32'(bus0.out), 32'(e.prod));
                check("ack_time0", 32'(cyc), 32'(e.due));
            end
        end
    end

    // Monitor for dut1.
    always @(negedge clk) begin
        exp_t e;
        if (bus1.ack === 1'b1) begin
            acks1++;
            if (q1.size() == 0) begin
                check("unexpected_ack1", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                check("prod1", 32'(bus1.out), 32'(e.prod));
                check("ack_time1", 32'(cyc), 32'(e.due));
            end
        end
    end

    // Issue one request when the target is idle; optionally wait for its ack.
    task automatic issue(input int which, input bit s, input logic [W-1:0] x,
                         input logic [W-1:0] y, input bit wait_done);
        int   t;
        exp_t e;
        bit   fast;
        t = 0;
        @(negedge clk);
        while (busy_of(which) && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (t >= 40) check("idle_timeout", 32'd1, 32'd0);
        if (which == 0) begin
            bus0.en = 1'b1; bus0.sgn = s; bus0.a = x; bus0.b = y;
        end else begin
            bus1.en = 1'b1; bus1.sgn = s; bus1.a = x; bus1.b = y;
        end
        fast = (which == 0) && ((x == '0) || (y == '0));
        @(posedge clk);
        #1;
        e.prod = ref_mul(s, x, y);
        e.due  = cyc + (fast ? 0 : mult_latency(W));
        if (which == 0) q0.push_back(e); else q1.push_back(e);
        @(negedge clk);
        if (which == 0) begin
            bus0.en = 1'b0; bus0.sgn = 1'($urandom); bus0.a = W'($urandom); bus0.b = W'($urandom);
            check("busy_rise0", 32'(bus0.busy), 32'd1);
            check("out_held0", 32'(bus0.out), 32'(fast ? e.prod : last_prod[0]));
        end else begin
            bus1.en = 1'b0; bus1.sgn = 1'($urandom); bus1.a = W'($urandom); bus1.b = W'($urandom);
            check("busy_rise1", 32'(bus1.busy), 32'd1);
            check("out_held1", 32'(bus1.out), 32'(last_prod[1]));
        end
        last_prod[which] = e.prod;
        if (wait_done) begin
            t = 0;
            while (qsize(which) != 0 && t < 40) begin
                @(negedge clk);
                t++;
            end
            if (t >= 40) begin
                check("ack_timeout", 32'd1, 32'd0);
                if (which == 0) q0.delete(); else q1.delete();
            end
        end
    endtask

    initial begin
        logic [W-1:0] x;
        logic [W-1:0] y;
        int           n0;
        last_prod[0] = '0;
        last_prod[1] = '0;
        bus0.en = 1'b0; bus0.sgn = 1'b0; bus0.a = '0; bus0.b = '0;
        bus1.en = 1'b0; bus1.sgn = 1'b0; bus1.a = '0; bus1.b = '0;
        reset = 1'b1;
        @(negedge clk);
        check("rst_out", 32'(bus0.out), 32'd0);
        check("rst_ack", 32'(bus0.ack), 32'd0);
        check("rst_busy", 32'(bus0.busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed cases.
        issue(0, 1'b0, 8'd5,   8'd6,   1'b1);
        issue(0, 1'b0, 8'd255, 8'd255, 1'b1);
        issue(0, 1'b1, 8'h80,  8'h80,  1'b1);
        issue(0, 1'b1, 8'hFD,  8'd7,   1'b1);
        issue(0, 1'b1, 8'hEC,  8'hF9,  1'b1);
        issue(0, 1'b0, 8'd0,   8'd9,   1'b1);
        issue(1, 1'b0, 8'd0,   8'd9,   1'b1);
        issue(1, 1'b1, 8'h7F,  8'h80,  1'b1);

        // Randomised traffic with some zero operands.
        for (int i = 0; i < 40; i++) begin
            x = W'($urandom);
            y = W'($urandom);
            if ($urandom_range(0, 7) == 0) x = '0;
            if ($urandom_range(0, 7) == 0) y = '0;
            issue(i % 4 == 3 ? 1 : 0, 1'($urandom), x, y, 1'b1);
        end

        // A request raised during CALC must be ignored.
        n0 = acks0;
        issue(0, 1'b0, 8'd20, 8'd7, 1'b0);
        bus0.en = 1'b1; bus0.a = 8'd1; bus0.b = 8'd1;
        repeat (3) @(negedge clk);
        bus0.en = 1'b0;
        for (int t = 0; t < 40 && q0.size() != 0; t++) @(negedge clk);
        @(negedge clk);
        check("single_ack", 32'(acks0 - n0), 32'd1);
        check("busy_fall", 32'(bus0.busy), 32'd0);
        repeat (W + 2) @(negedge clk);
        check("no_extra_ack", 32'(acks0 - n0), 32'd1);

        // Reset in the middle of CALC aborts without an ack.
        n0 = acks0;
        bus0.en = 1'b1; bus0.sgn = 1'b0; bus0.a = 8'd10; bus0.b = 8'd4;
        @(negedge clk);
        bus0.en = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_out", 32'(bus0.out), 32'd0);
        check("abort_ack", 32'(bus0.ack), 32'd0);
        check("abort_busy", 32'(bus0.busy), 32'd0);
        last_prod[0] = '0;
        last_prod[1] = '0;
        repeat (W + 4) @(negedge clk);
        check("abort_no_ack", 32'(acks0 - n0), 32'd0);
        issue(0, 1'b0, 8'd10, 8'd4, 1'b1);

        repeat (3) @(negedge clk);
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Backstop in case something stalls outside the bounded waits.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mult_seq
